user_power_sequencer: RTL and testbench

- Consumes the level-shifted power-present flags `mprj_vdd_logic1` and `mprj2_vdd_logic1` coming from the HV protection stage.
- Synchronises, debounces and sequences them into clean per-domain power-good and interface-enable signals.
- Its outputs gate the management-to-user-area isolation inside mgmt_protect.
- A drop on either domain forces that domain back to isolation immediately and logs a sticky fault.

---
 rtl/user_power_pkg.sv | 5 +
 rtl/power_domain_seq.sv | 58 +++++
 rtl/user_power_sequencer.sv | 46 ++++
 tb/tb_user_power_sequencer.sv | 118 +++++++++++
 4 files changed

// File: rtl/user_power_pkg.sv
// user_power_pkg: shared state encoding and constants for the user power sequencer
package user_power_pkg;
    typedef enum logic [1:0] {OFF = 2'd0, DEBOUNCE = 2'd1, SETTLE = 2'd2, ON = 2'd3} pwr_state_t;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/power_domain_seq.sv
// power_domain_seq: synchronise, debounce and sequence one domain's power-present flag
module power_domain_seq
    import user_power_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 8,
    parameter int CNT_W           = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_vdd,
    input  logic       i_ena,
    output logic       o_powergood,
    output logic       o_iena,
    output logic       o_fault_set,
    output pwr_state_t o_state
);
    // counter holds (cycles counted - 1) so a full 2**CNT_W window still fits in CNT_W bits
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    pwr_state_t             r_state, w_state_nxt;
    logic                   w_sync;
    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_state <= OFF;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_vdd};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            OFF:      w_state_nxt = w_sync ? DEBOUNCE : OFF;
            DEBOUNCE: begin
                w_state_nxt = !w_sync ? OFF : (r_cnt == DB_LAST) ? SETTLE : DEBOUNCE;
                w_cnt_nxt   = (w_sync && r_cnt != DB_LAST) ? w_cnt_inc : '0;
            end
            SETTLE: begin
                w_state_nxt = !w_sync ? OFF : (r_cnt == ST_LAST) ? ON : SETTLE;
                w_cnt_nxt   = (w_sync && r_cnt != ST_LAST) ? w_cnt_inc : '0;
            end
            default:  w_state_nxt = w_sync ? ON : OFF;
        endcase
    end
    assign o_state     = r_state;
    assign o_powergood = (r_state == SETTLE) || (r_state == ON);
    assign o_iena      = (r_state == ON) && i_ena;
    assign o_fault_set = (r_state == ON) && !w_sync;
endmodule

// File: rtl/user_power_sequencer.sv
// user_power_sequencer: per-domain power-good/interface-enable sequencing with sticky drop faults
module user_power_sequencer
    import user_power_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 8,
    parameter int CNT_W           = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       mprj_vdd_logic1,
    input  logic       mprj2_vdd_logic1,
    input  logic       user_enable,
    input  logic       fault_clr,
    output logic       user1_powergood,
    output logic       user2_powergood,
    output logic       mprj_iena_wb,
    output logic       user2_iena,
    output logic [1:0] fault_sticky,
    output logic [3:0] seq_state
);
    logic       r_ena_q;
    logic [1:0] r_fault;
    logic [1:0] w_fault_set;
    pwr_state_t w_st1, w_st2;
    power_domain_seq #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)) u_dom1 (
        .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_vdd(mprj_vdd_logic1), .i_ena(r_ena_q),
        .o_powergood(user1_powergood), .o_iena(mprj_iena_wb), .o_fault_set(w_fault_set[0]), .o_state(w_st1)
    );
    power_domain_seq #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)) u_dom2 (
        .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_vdd(mprj2_vdd_logic1), .i_ena(r_ena_q),
        .o_powergood(user2_powergood), .o_iena(user2_iena), .o_fault_set(w_fault_set[1]), .o_state(w_st2)
    );
    // a new drop on the clearing edge must survive, so set is OR-ed in after the clear
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ena_q <= 1'b0;
            r_fault <= '0;
        end else begin
            r_ena_q <= user_enable;
            r_fault <= (r_fault & ~{2{fault_clr}}) | w_fault_set;
        end
    end
    assign fault_sticky = r_fault;
    assign seq_state    = {w_st2, w_st1};
endmodule

// File: tb/tb_user_power_sequencer.sv
// tb_user_power_sequencer: directed stimulus with a queued scoreboard checked on the falling edge
module tb_user_power_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vdd1 = 1'b0, vdd2 = 1'b0, uen = 1'b0, fclr = 1'b0;
    logic       pg1, pg2, ie1, ie2;
    logic [1:0] fault;
    logic [3:0] st;
    typedef struct {
        string      name;
        logic [9:0] exp;
    } item_t;
    item_t q[$];
    int    n_vec = 0;
    int    n_err = 0;
    always #5 clk = ~clk;
    user_power_sequencer dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .mprj_vdd_logic1(vdd1), .mprj2_vdd_logic1(vdd2),
        .user_enable(uen), .fault_clr(fclr), .user1_powergood(pg1), .user2_powergood(pg2),
        .mprj_iena_wb(ie1), .user2_iena(ie2), .fault_sticky(fault), .seq_state(st)
    );
    always @(negedge clk) begin
        while (q.size() > 0) begin
            item_t it;
            logic [9:0] act;
            it  = q.pop_front();
            act = {pg1, pg2, ie1, ie2, fault, st};
            n_vec++;
            if (act !== it.exp) begin
                n_err++;
                $display("FAIL %s: got pg1,pg2,ie1,ie2,fault,st=%b want %b", it.name, act, it.exp);
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic p1, input logic p2, input logic i1, input logic i2,
                       input logic [1:0] f, input logic [3:0] s);
        item_t it;
        it.name = name;
        it.exp  = {p1, p2, i1, i2, f, s};
        q.push_back(it);
    endtask
    initial begin
        tick(2);
        chk("reset", 0, 0, 0, 0, 2'b00, 4'h0);
        rst = 0;
        vdd1 = 1; uen = 1;
        tick(1);  chk("d1_e0", 0, 0, 0, 0, 2'b00, 4'h0);
        tick(1);  chk("d1_e1", 0, 0, 0, 0, 2'b00, 4'h0);
        tick(1);  chk("d1_debounce_e2", 0, 0, 0, 0, 2'b00, 4'h1);
        tick(15); chk("d1_debounce_e17", 0, 0, 0, 0, 2'b00, 4'h1);
        tick(1);  chk("d1_pg_e18", 1, 0, 0, 0, 2'b00, 4'h2);
        tick(7);  chk("d1_settle_e25", 1, 0, 0, 0, 2'b00, 4'h2);
        tick(1);  chk("d1_on_e26", 1, 0, 1, 0, 2'b00, 4'h3);
        vdd2 = 1;
        tick(1);  chk("d2_e0", 1, 0, 1, 0, 2'b00, 4'h3);
        tick(2);  chk("d2_debounce", 1, 0, 1, 0, 2'b00, 4'h7);
        tick(9);  chk("d2_cnt10", 1, 0, 1, 0, 2'b00, 4'h7);
        vdd2 = 0;
        tick(1);  chk("d2_glitch_j", 1, 0, 1, 0, 2'b00, 4'h7);
        vdd2 = 1;
        tick(1);  chk("d2_glitch_j1", 1, 0, 1, 0, 2'b00, 4'h7);
        tick(1);  chk("d2_glitch_off", 1, 0, 1, 0, 2'b00, 4'h3);
        tick(1);  chk("d2_redebounce", 1, 0, 1, 0, 2'b00, 4'h7);
        tick(15); chk("d2_redebounce_end", 1, 0, 1, 0, 2'b00, 4'h7);
        tick(1);  chk("d2_pg", 1, 1, 1, 0, 2'b00, 4'hB);
        tick(8);  chk("d2_on", 1, 1, 1, 1, 2'b00, 4'hF);
        vdd1 = 0;
        tick(1);  chk("d1_drop_k", 1, 1, 1, 1, 2'b00, 4'hF);
        tick(1);  chk("d1_drop_k1", 1, 1, 1, 1, 2'b00, 4'hF);
        tick(1);  chk("d1_drop_k2", 0, 1, 0, 1, 2'b01, 4'hC);
        tick(5);  chk("fault_hold", 0, 1, 0, 1, 2'b01, 4'hC);
        fclr = 1;
        tick(1);  chk("fault_clr", 0, 1, 0, 1, 2'b00, 4'hC);
        fclr = 0;
        vdd2 = 0;
        tick(2);  chk("d2_drop_k1", 0, 1, 0, 1, 2'b00, 4'hC);
        fclr = 1;
        tick(1);  chk("set_wins", 0, 0, 0, 0, 2'b10, 4'h0);
        fclr = 0;
        tick(1);
        fclr = 1;
        tick(1);  chk("fault_clr2", 0, 0, 0, 0, 2'b00, 4'h0);
        fclr = 0;
        vdd1 = 1; vdd2 = 1;
        tick(1);
        tick(26); chk("both_on", 1, 1, 1, 1, 2'b00, 4'hF);
        uen = 0;
        tick(1);  chk("uen_low", 1, 1, 0, 0, 2'b00, 4'hF);
        tick(2);  chk("uen_low_hold", 1, 1, 0, 0, 2'b00, 4'hF);
        uen = 1;
        tick(1);  chk("uen_high", 1, 1, 1, 1, 2'b00, 4'hF);
        rst = 1;
        tick(1);  chk("rst_from_on", 0, 0, 0, 0, 2'b00, 4'h0);
        rst = 0;
        tick(1);
        tick(18); chk("settle_before_rst", 1, 1, 0, 0, 2'b00, 4'hA);
        tick(1);
        rst = 1;
        tick(1);  chk("rst_in_settle", 0, 0, 0, 0, 2'b00, 4'h0);
        rst = 0;
        tick(1);  chk("restart_e0", 0, 0, 0, 0, 2'b00, 4'h0);
        tick(16); chk("restart_e16", 0, 0, 0, 0, 2'b00, 4'h5);
        tick(2);  chk("restart_pg_e18", 1, 1, 0, 0, 2'b00, 4'hA);
        tick(7);  chk("restart_e25", 1, 1, 0, 0, 2'b00, 4'hA);
        tick(1);  chk("restart_on_e26", 1, 1, 1, 1, 2'b00, 4'hF);
        tick(2);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
